ulight_fifo_timecode_tx_ctrl: RTL

//   Sits between the 8-bit timecode PIO register and the SpaceWire core tick interface.

---
 rtl/ulight_fifo_timecode_tx_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/ulight_fifo_timecode_tx_ctrl.sv
// Timecode transmit controller: turns PIO timecode writes and optional periodic
// auto-increment requests into spaced single-cycle tick_in pulses for the SpaceWire core.
module ulight_fifo_timecode_tx_ctrl #(
  parameter int PERIOD_CYCLES = 10000,
  parameter int GAP_CYCLES    = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  pio_data,
  input  logic        auto_en,
  input  logic        link_running,
  output logic        tick_in,
  output logic [1:0]  ctrl_in,
  output logic [5:0]  time_in,
  output logic        pending,
  output logic [15:0] tick_cnt
);

  localparam int PW = (PERIOD_CYCLES > 1) ? $clog2(PERIOD_CYCLES) : 1;
  localparam int GW = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES - 1) : 1;
  localparam logic [PW-1:0] PERIOD_LAST = PW'(PERIOD_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LOAD    = GW'((GAP_CYCLES >= 2) ? (GAP_CYCLES - 2) : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [7:0]    pio_q;
  logic          pio_valid;
  logic          link_q;
  logic [PW-1:0] period_cnt;
  logic          auto_req;
  logic [GW-1:0] gap_cnt;

  logic decide;
  logic req_manual;
  logic req_auto;
  logic wrap;
  logic pio_changed;

  // A send decision is taken while idle, or on the last hold cycle so ticks land exactly GAP_CYCLES apart.
  assign decide      = (state == IDLE) || ((state == HOLD) && (gap_cnt == '0));
  assign req_manual  = decide && link_q && pending;
  assign req_auto    = decide && link_q && !pending && auto_req;
  assign wrap        = auto_en && (period_cnt == PERIOD_LAST);
  assign pio_changed = pio_valid && (pio_data != pio_q);
  assign tick_in     = (state == SEND);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_manual || req_auto) state_next = SEND;
      end
      SEND: begin
        state_next = (GAP_CYCLES > 1) ? HOLD : IDLE;
      end
      HOLD: begin
        if (gap_cnt == '0) state_next = (req_manual || req_auto) ? SEND : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // pio_valid masks the first compare after reset so a stale PIO value never fires a tick.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pio_q     <= 8'h00;
      pio_valid <= 1'b0;
      link_q    <= 1'b0;
      pending   <= 1'b0;
    end else begin
      pio_q     <= pio_data;
      pio_valid <= 1'b1;
      link_q    <= link_running;
      pending   <= (pending && !req_manual) || pio_changed;
    end
  end

  // An auto request survives hold only while the link stays up; any decision cycle consumes or drops it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_cnt <= '0;
      auto_req   <= 1'b0;
    end else begin
      if (!auto_en || wrap) begin
        period_cnt <= '0;
      end else begin
        period_cnt <= period_cnt + 1'b1;
      end
      if (wrap) begin
        auto_req <= 1'b1;
      end else if (decide || !link_q) begin
        auto_req <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gap_cnt <= '0;
    end else if (state == SEND) begin
      gap_cnt <= GAP_LOAD;
    end else if ((state == HOLD) && (gap_cnt != '0)) begin
      gap_cnt <= gap_cnt - 1'b1;
    end
  end

  // time_in doubles as the running time counter that auto ticks increment.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_in  <= 2'b00;
      time_in  <= 6'd0;
      tick_cnt <= 16'd0;
    end else if (req_manual) begin
      ctrl_in  <= pio_q[7:6];
      time_in  <= pio_q[5:0];
      tick_cnt <= tick_cnt + 16'd1;
    end else if (req_auto) begin
      ctrl_in  <= 2'b00;
      time_in  <= time_in + 6'd1;
      tick_cnt <= tick_cnt + 16'd1;
    end
  end

endmodule
